soc_ifc_fuse_wr_seq: RTL

// - SoC-side fuse write sequencer: the initiator that drives the fuse-programming handshake the boot FSM responds to.
// - Waits for ready_for_fuses, then streams NUM_FUSE_WORDS words to the fuse register write port, one at a time.
// - Finally writes the fuse_done register, which produces fuse_wr_done_observed on the Caliptra side.
// - Sits in the SoC/testbench integration layer next to soc_ifc, on the same clock.

---
 rtl/soc_ifc_fuse_wr_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/soc_ifc_fuse_wr_seq.sv
// SoC-side fuse write sequencer: waits for the boot FSM to request fuses,
// streams NUM_FUSE_WORDS words to the fuse register write port, then writes
// the fuse_done register. Flags sticky completion / error status.
module soc_ifc_fuse_wr_seq #(
    parameter int unsigned NUM_FUSE_WORDS = 16,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ACK_TIMEOUT    = 255
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    ready_for_fuses,
    input  logic                                    fuse_done,
    input  logic                                    src_valid,
    input  logic [DATA_W-1:0]                       src_data,
    output logic                                    src_ready,
    output logic                                    fuse_wr_en,
    output logic [ADDR_W-1:0]                       fuse_wr_addr,
    output logic [DATA_W-1:0]                       fuse_wr_data,
    output logic                                    fuse_wr_is_done,
    input  logic                                    fuse_wr_ack,
    output logic                                    busy,
    output logic                                    complete,
    output logic                                    err_timeout,
    output logic [$clog2(NUM_FUSE_WORDS+1)-1:0]     words_written
);

    localparam int unsigned CNT_W = $clog2(NUM_FUSE_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        FETCH,
        WRITE,
        DONE_WR,
        COMPLETE,
        ERROR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        ack_cnt;
    logic [DATA_W-1:0] word_q;

    logic can_start;
    logic in_write;
    logic ack_expired;
    logic last_word;
    logic data_acked;

    // words_written doubles as the write index: both advance only on a data ack
    assign can_start   = start && ((state == IDLE) || (state == COMPLETE) || (state == ERROR));
    assign in_write    = (state == WRITE) || (state == DONE_WR);
    assign ack_expired = (ack_cnt == 8'(ACK_TIMEOUT - 1)) && !fuse_wr_ack;
    assign last_word   = (words_written == CNT_W'(NUM_FUSE_WORDS - 1));
    assign data_acked  = (state == WRITE) && ready_for_fuses && fuse_wr_ack;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a ready_for_fuses drop beats ack, ack beats timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE, COMPLETE, ERROR: begin
                if (start) state_next = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (ready_for_fuses) state_next = fuse_done ? DONE_WR : FETCH;
            end
            FETCH: begin
                if (!ready_for_fuses) state_next = ERROR;
                else if (src_valid)   state_next = WRITE;
            end
            WRITE: begin
                if (!ready_for_fuses) state_next = ERROR;
                else if (fuse_wr_ack) state_next = last_word ? DONE_WR : FETCH;
                else if (ack_expired) state_next = ERROR;
            end
            DONE_WR: begin
                if (!ready_for_fuses) state_next = ERROR;
                else if (fuse_wr_ack) state_next = COMPLETE;
                else if (ack_expired) state_next = ERROR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        src_ready       = 1'b0;
        fuse_wr_en      = 1'b0;
        fuse_wr_addr    = '0;
        fuse_wr_data    = '0;
        fuse_wr_is_done = 1'b0;
        busy            = 1'b0;
        case (state)
            WAIT_RDY: begin
                busy = 1'b1;
            end
            FETCH: begin
                busy      = 1'b1;
                src_ready = 1'b1;
            end
            WRITE: begin
                busy         = 1'b1;
                fuse_wr_en   = 1'b1;
                fuse_wr_addr = ADDR_W'(words_written);
                fuse_wr_data = word_q;
            end
            DONE_WR: begin
                busy            = 1'b1;
                fuse_wr_en      = 1'b1;
                fuse_wr_is_done = 1'b1;
                fuse_wr_data    = DATA_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath: word latch, write count, ack wait counter, sticky status
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q        <= '0;
            words_written <= '0;
            ack_cnt       <= '0;
            complete      <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            if (can_start) begin
                words_written <= '0;
                complete      <= 1'b0;
                err_timeout   <= 1'b0;
            end
            if ((state == FETCH) && src_valid) begin
                word_q <= src_data;
            end
            if (data_acked) begin
                words_written <= words_written + CNT_W'(1);
            end
            if (in_write && !fuse_wr_ack) begin
                ack_cnt <= ack_cnt + 8'd1;
            end else begin
                ack_cnt <= '0;
            end
            if ((state == DONE_WR) && (state_next == COMPLETE)) begin
                complete <= 1'b1;
            end
            if ((state_next == ERROR) && (state != ERROR)) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule
